// File: rtl/truth_table_extractor.sv
// Sweeps every input vector of an N_IN-input gate and rebuilds its rule code (k=0 lands in the MSB).
// Optional macro TRUTH_TABLE_EXTRACTOR_VOTE_EN: three samples per vector, 2-of-3 majority, sticky unstable flag.
module truth_table_extractor #(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   rule,
  output logic                   rule_valid,
  output logic                   unstable
);

  localparam int unsigned RW = 1 << N_IN;
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 2);
`else
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
`endif

  // cnt_q counts edges since dut_in last changed; the sample edge is when cnt_q == SAMPLE_AT
  localparam logic [CW-1:0]   SAMPLE_AT   = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'((SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0);
  localparam logic [N_IN:0]   K_LAST      = (N_IN+1)'(RW - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam state_t FIRST_ST = (SETTLE_CYCLES == 1) ? SAMPLE : SETTLE;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   k_q, k_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [RW-1:0]   rule_q, rule_d;
  logic            rule_valid_q, rule_valid_d;
  logic            unstable_q, unstable_d;
  logic            sample;
  logic            finish;
  logic [N_IN-1:0] idx;
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
  logic [1:0]      vote_q, vote_d;
  logic            disagree;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rule_q       <= '0;
      rule_valid_q <= 1'b0;
      unstable_q   <= 1'b0;
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
      vote_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rule_q       <= rule_d;
      rule_valid_q <= rule_valid_d;
      unstable_q   <= unstable_d;
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
      vote_q       <= vote_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rule_d       = rule_q;
    rule_valid_d = rule_valid_q;
    unstable_d   = unstable_q;
    sample       = dut_out;
    finish       = 1'b0;
    // RW-1-k equals the bitwise inverse of k over N_IN bits
    idx          = ~k_q[N_IN-1:0];
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
    vote_d       = vote_q;
    disagree     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        dut_in_d = '0;
        if (start && !abort) begin
          busy_d       = 1'b1;
          rule_valid_d = 1'b0;
          unstable_d   = 1'b0;
          k_d          = '0;
          cnt_d        = '0;
          state_d      = FIRST_ST;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end

      SAMPLE: begin
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
        if (cnt_q == SAMPLE_AT) begin
          vote_d[0] = dut_out;
          cnt_d     = cnt_q + 1'b1;
        end else if (cnt_q == SAMPLE_AT + 1'b1) begin
          vote_d[1] = dut_out;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          sample   = (vote_q[0] & vote_q[1]) | (vote_q[0] & dut_out) | (vote_q[1] & dut_out);
          disagree = (vote_q[0] != vote_q[1]) || (vote_q[1] != dut_out);
          finish   = 1'b1;
        end
        if (disagree) unstable_d = 1'b1;
`else
        finish = 1'b1;
`endif
        if (finish) begin
          rule_d[idx] = sample;
          cnt_d       = '0;
          if (k_q == K_LAST) begin
            state_d      = DONE;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            rule_valid_d = 1'b1;
            dut_in_d     = '0;
          end else begin
            k_d      = k_q + (N_IN+1)'(1);
            dut_in_d = k_d[N_IN-1:0];
            state_d  = FIRST_ST;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // abort overrides everything, including a final sample landing on the same edge
    if (abort && busy_q) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      dut_in_d     = '0;
      rule_valid_d = 1'b0;
      cnt_d        = '0;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rule       = rule_q;
  assign rule_valid = rule_valid_q;
  assign unstable   = unstable_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor driving a gate model whose output lags dut_in by SETTLE-1 cycles.
module tb_truth_table_extractor;

  localparam int unsigned N_IN = 3;
  localparam int unsigned S    = 4;
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
  localparam int PER = S + 2;
`else
  localparam int PER = S;
`endif
  localparam int SWEEP   = 8 * PER;
  localparam int TIMEOUT = 400;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, dut_out;
  logic       busy, done, rule_valid, unstable;
  logic [2:0] dut_in;
  logic [7:0] rule;
  logic [7:0] gate_rule;
  logic       glitch;
  logic [2:0] dly [0:S-2];
  int         tests = 0;
  int         fails = 0;

  truth_table_extractor #(.N_IN(N_IN), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .rule(rule), .rule_valid(rule_valid), .unstable(unstable)
  );

  always #5 clk = ~clk;

  // gate output becomes valid exactly S-1 edges after dut_in changes, so only the S-th edge sees it
  always @(posedge clk) begin
    dly[0] <= dut_in;
    for (int i = 1; i < S - 1; i++) dly[i] <= dly[i-1];
  end
  assign dut_out = gate_rule[3'd7 - dly[S-2]] ^ glitch;

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        at = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; glitch = 1'b0; gate_rule = 8'h73;
    #2;
    tests++; if (dut_in !== 3'd0)     begin fails++; $display("FAIL reset_dut_in got %h want 0", dut_in); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)       begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (rule !== 8'h00)      begin fails++; $display("FAIL reset_rule got %h want 00", rule); end
    tests++; if (rule_valid !== 1'b0) begin fails++; $display("FAIL reset_rule_valid got %b want 0", rule_valid); end
    tests++; if (unstable !== 1'b0)   begin fails++; $display("FAIL reset_unstable got %b want 0", unstable); end
    #20 rst_n = 1'b1;
    repeat (4) idle_cycle();
    tests++; if (busy !== 1'b0 || dut_in !== 3'd0) begin
      fails++; $display("FAIL idle_after_reset busy=%b dut_in=%h want 0/0", busy, dut_in);
    end
  endtask

  task automatic test_rule_73();
    int at;
    gate_rule = 8'h73;
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL r73_busy_at_start got %b want 1", busy); end
    wait_done(at);
    tests++; if (at != SWEEP)         begin fails++; $display("FAIL r73_done_edge got %0d want %0d", at, SWEEP); end
    tests++; if (rule !== 8'h73)      begin fails++; $display("FAIL r73_rule got %h want 73", rule); end
    tests++; if (rule_valid !== 1'b1) begin fails++; $display("FAIL r73_rule_valid got %b want 1", rule_valid); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL r73_busy_end got %b want 0", busy); end
    tests++; if (dut_in !== 3'd0)     begin fails++; $display("FAIL r73_dut_in_end got %h want 0", dut_in); end
    tests++; if (unstable !== 1'b0)   begin fails++; $display("FAIL r73_unstable got %b want 0", unstable); end
    idle_cycle();
    tests++; if (done !== 1'b0)       begin fails++; $display("FAIL r73_done_pulse_width got %b want 0", done); end
    tests++; if (rule !== 8'h73 || rule_valid !== 1'b1) begin
      fails++; $display("FAIL r73_hold rule=%h valid=%b want 73/1", rule, rule_valid);
    end
  endtask

  task automatic test_constant_gates();
    int at;
    logic [2:0] exp;
    gate_rule = 8'h00;
    pulse_start();
    tests++; if (dut_in !== 3'd0) begin fails++; $display("FAIL c0_dut_in edge 0 got %h want 0", dut_in); end
    for (int n = 1; n <= SWEEP; n++) begin
      @(posedge clk); #1;
      exp = (n < SWEEP) ? 3'(n / PER) : 3'd0;
      tests++; if (dut_in !== exp) begin
        fails++; $display("FAIL c0_dut_in edge %0d got %h want %h", n, dut_in, exp);
      end
    end
    tests++; if (done !== 1'b1)  begin fails++; $display("FAIL c0_done got %b want 1", done); end
    tests++; if (rule !== 8'h00) begin fails++; $display("FAIL c0_rule got %h want 00", rule); end
    idle_cycle();
    gate_rule = 8'hFF;
    repeat (S) idle_cycle();
    pulse_start();
    wait_done(at);
    tests++; if (at != SWEEP)         begin fails++; $display("FAIL c1_done_edge got %0d want %0d", at, SWEEP); end
    tests++; if (rule !== 8'hFF)      begin fails++; $display("FAIL c1_rule got %h want FF", rule); end
    tests++; if (rule_valid !== 1'b1) begin fails++; $display("FAIL c1_rule_valid got %b want 1", rule_valid); end
    idle_cycle();
  endtask

  task automatic test_abort();
    int at;
    logic saw_done;
    gate_rule = 8'h73;
    repeat (S) idle_cycle();
    pulse_start();
    repeat (9) idle_cycle();
    abort = 1'b1;
    idle_cycle();
    abort = 1'b0;
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)       begin fails++; $display("FAIL abort_done got %b want 0", done); end
    tests++; if (rule_valid !== 1'b0) begin fails++; $display("FAIL abort_rule_valid got %b want 0", rule_valid); end
    tests++; if (dut_in !== 3'd0)     begin fails++; $display("FAIL abort_dut_in got %h want 0", dut_in); end
    saw_done = 1'b0;
    for (int n = 0; n < SWEEP + 8; n++) begin
      idle_cycle();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL abort_no_done got activity=%b want 0", saw_done); end
    start = 1'b1; abort = 1'b1;
    idle_cycle();
    start = 1'b0; abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_beats_start busy got %b want 0", busy); end
    pulse_start();
    wait_done(at);
    tests++; if (at != SWEEP)    begin fails++; $display("FAIL abort_restart_done_edge got %0d want %0d", at, SWEEP); end
    tests++; if (rule !== 8'h73) begin fails++; $display("FAIL abort_restart_rule got %h want 73", rule); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int at;
    gate_rule = 8'h5A;
    repeat (S) idle_cycle();
    pulse_start();
    at = -1;
    for (int n = 1; n <= TIMEOUT; n++) begin
      start = (n == 3 || n == 10 || n == 20 || n == 31);
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        at = n;
        break;
      end
    end
    tests++; if (at != SWEEP)    begin fails++; $display("FAIL b2b_done_edge got %0d want %0d", at, SWEEP); end
    tests++; if (rule !== 8'h5A) begin fails++; $display("FAIL b2b_rule got %h want 5A", rule); end
    pulse_start();
    tests++; if (busy !== 1'b0 || rule_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_start_in_done busy=%b valid=%b want 0/1", busy, rule_valid);
    end
    pulse_start();
    tests++; if (busy !== 1'b1 || rule_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_restart busy=%b valid=%b want 1/0", busy, rule_valid);
    end
    wait_done(at);
    tests++; if (at != SWEEP || rule !== 8'h5A) begin
      fails++; $display("FAIL b2b_second_sweep edge=%0d rule=%h want %0d/5A", at, rule, SWEEP);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int at;
    gate_rule = 8'h73;
    repeat (S) idle_cycle();
    pulse_start();
    repeat (13) idle_cycle();
    #3 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tests++; if (dut_in !== 3'd0)     begin fails++; $display("FAIL rstmid_dut_in got %h want 0", dut_in); end
    tests++; if (rule !== 8'h00)      begin fails++; $display("FAIL rstmid_rule got %h want 00", rule); end
    tests++; if (rule_valid !== 1'b0 || done !== 1'b0 || unstable !== 1'b0) begin
      fails++; $display("FAIL rstmid_flags valid=%b done=%b unstable=%b want 0/0/0", rule_valid, done, unstable);
    end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || rule !== 8'h00) begin
      fails++; $display("FAIL rstmid_held busy=%b rule=%h want 0/00", busy, rule);
    end
    rst_n = 1'b1;
    repeat (S) idle_cycle();
    pulse_start();
    wait_done(at);
    tests++; if (at != SWEEP || rule !== 8'h73) begin
      fails++; $display("FAIL rstmid_recover edge=%0d rule=%h want %0d/73", at, rule, SWEEP);
    end
    idle_cycle();
  endtask

`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
  task automatic test_vote_glitch();
    int at;
    gate_rule = 8'h73;
    repeat (S) idle_cycle();
    pulse_start();
    at = -1;
    for (int n = 1; n <= TIMEOUT; n++) begin
      glitch = (n == 5 * PER + S + 1);
      @(posedge clk); #1;
      glitch = 1'b0;
      if (done === 1'b1) begin
        at = n;
        break;
      end
    end
    tests++; if (at != 48)          begin fails++; $display("FAIL vote_done_edge got %0d want 48", at); end
    tests++; if (rule !== 8'h73)    begin fails++; $display("FAIL vote_rule got %h want 73", rule); end
    tests++; if (unstable !== 1'b1) begin fails++; $display("FAIL vote_unstable got %b want 1", unstable); end
    idle_cycle();
    tests++; if (unstable !== 1'b1) begin fails++; $display("FAIL vote_unstable_sticky got %b want 1", unstable); end
    pulse_start();
    tests++; if (unstable !== 1'b0) begin fails++; $display("FAIL vote_unstable_clear got %b want 0", unstable); end
    wait_done(at);
    tests++; if (at != 48 || rule !== 8'h73 || unstable !== 1'b0) begin
      fails++; $display("FAIL vote_clean_sweep edge=%0d rule=%h unstable=%b want 48/73/0", at, rule, unstable);
    end
    idle_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_rule_73();
    test_constant_gates();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef TRUTH_TABLE_EXTRACTOR_VOTE_EN
    test_vote_glitch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
